// File: rtl/cmd_intf_q_if.sv
// Command and station-ID handshake bundle between the upstream receivers and cmd_intf_q.
// Both valids are levels held by the producer until the matching clear is seen.
interface cmd_intf_q_if;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic [7:0] ID;
    logic       ID_vld;
    logic       clr_ID_vld;

    modport master (
        output cmd, cmd_rdy, ID, ID_vld,
        input  clr_cmd_rdy, clr_ID_vld
    );

    modport slave (
        input  cmd, cmd_rdy, ID, ID_vld,
        output clr_cmd_rdy, clr_ID_vld
    );
endinterface

// File: rtl/cmd_intf_q.sv
// Robot command interface with a FIFO route of destination stations and an obstruction buzzer.
// Define CMD_INTF_BUZZER_EN to build the buzzer; otherwise buzz/buzz_n are tied inactive.
module cmd_intf_q #(
    parameter int unsigned ID_W      = 6,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned BUZZ_HALF = 6250
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cmd_intf_q_if.slave            bus,
    input  logic                   OK2Move,
    output logic                   go,
    output logic                   in_transit,
    output logic                   arrived,
    output logic                   cmd_err,
    output logic [$clog2(DEPTH):0] route_cnt,
    output logic                   buzz,
    output logic                   buzz_n
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    if (ID_W < 1 || ID_W > 6 || DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
        BUZZ_HALF < 2) begin : gen_bad_params
        $error("cmd_intf_q: illegal parameter value");
    end

    typedef enum logic [0:0] {StIdle, StMove} state_e;

    state_e          state_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [ID_W-1:0] fifo_q [DEPTH];

    logic [1:0]      opcode;
    logic            cmd_stop;
    logic            cmd_go;
    logic            cmd_queue;
    logic [ID_W-1:0] dest;
    logic [ID_W-1:0] head;
    logic            full;
    logic            id_eval;
    logic            pop;
    logic            push;

    assign opcode    = bus.cmd[7:6];
    assign cmd_stop  = bus.cmd_rdy & (opcode == 2'b00);
    assign cmd_go    = bus.cmd_rdy & (opcode == 2'b01);
    assign cmd_queue = bus.cmd_rdy & (opcode == 2'b10);
    assign dest      = bus.cmd[ID_W-1:0];
    assign head      = fifo_q[rd_ptr_q];
    assign full      = (route_cnt == CntW'(DEPTH));

    // STOP/GO win over a pending station ID; the ID is left for the next cycle.
    assign id_eval = bus.ID_vld & ~(cmd_stop | cmd_go);
    assign pop     = id_eval & (state_q == StMove) & (bus.ID[ID_W-1:0] == head);
    assign push    = cmd_queue & (~full | pop);

    assign bus.clr_cmd_rdy = bus.cmd_rdy;
    assign bus.clr_ID_vld  = id_eval;
    assign arrived         = pop;
    assign cmd_err         = cmd_queue & full & ~pop;
    assign go              = in_transit & OK2Move;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            in_transit <= 1'b0;
            route_cnt  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else if (cmd_stop) begin
            state_q    <= StIdle;
            in_transit <= 1'b0;
            route_cnt  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else if (cmd_go) begin
            fifo_q[0]  <= dest;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= PtrW'(1);
            route_cnt  <= CntW'(1);
            state_q    <= StMove;
            in_transit <= 1'b1;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= dest;
                wr_ptr_q         <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                route_cnt <= route_cnt + CntW'(1);
            end else if (pop && !push) begin
                route_cnt <= route_cnt - CntW'(1);
            end
            if (push) begin
                state_q    <= StMove;
                in_transit <= 1'b1;
            end else if (pop && route_cnt == CntW'(1)) begin
                state_q    <= StIdle;
                in_transit <= 1'b0;
            end
        end
    end

`ifdef CMD_INTF_BUZZER_EN
    localparam int unsigned BuzzW = $clog2(BUZZ_HALF);

    logic [BuzzW-1:0] buzz_cnt_q;
    logic             buzz_en;

    assign buzz_en = in_transit & ~OK2Move;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buzz_cnt_q <= '0;
            buzz       <= 1'b0;
            buzz_n     <= 1'b1;
        end else if (!buzz_en) begin
            buzz_cnt_q <= '0;
            buzz       <= 1'b0;
            buzz_n     <= 1'b1;
        end else if (buzz_cnt_q == BuzzW'(BUZZ_HALF - 1)) begin
            buzz_cnt_q <= '0;
            buzz       <= ~buzz;
            buzz_n     <= ~buzz_n;
        end else begin
            buzz_cnt_q <= buzz_cnt_q + BuzzW'(1);
        end
    end
`else
    assign buzz   = 1'b0;
    assign buzz_n = 1'b1;
`endif

    // Upper cmd/ID bits beyond ID_W carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.cmd, bus.ID};

`ifndef SYNTHESIS
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        route_cnt <= CntW'(DEPTH));
    a_transit_cnt: assert property (@(posedge clk) disable iff (!rst_n)
        in_transit == (route_cnt != '0));
    a_buzz_compl: assert property (@(posedge clk) disable iff (!rst_n)
        buzz_n == ~buzz);
`endif

endmodule

// File: tb/tb_cmd_intf_q.sv
// Bench for cmd_intf_q: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based route model.
module tb_cmd_intf_q;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned BUZZ_HALF = 4;

    logic       clk;
    logic       rst_n;
    logic       OK2Move;
    logic       go;
    logic       in_transit;
    logic       arrived;
    logic       cmd_err;
    logic [2:0] route_cnt;
    logic       buzz;
    logic       buzz_n;

    cmd_intf_q_if bus ();

    cmd_intf_q #(
        .ID_W      (6),
        .DEPTH     (DEPTH),
        .BUZZ_HALF (BUZZ_HALF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .OK2Move    (OK2Move),
        .go         (go),
        .in_transit (in_transit),
        .arrived    (arrived),
        .cmd_err    (cmd_err),
        .route_cnt  (route_cnt),
        .buzz       (buzz),
        .buzz_n     (buzz_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Route model: the FIFO is just a queue of destinations.
    logic [5:0] route [$];
    int         buzz_run = 0;

    // Values captured during the last applied cycle.
    logic a_clr_id, a_arr, a_err, a_tr;
    logic [2:0] a_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit rdy, input logic [7:0] c, input bit vld, input logic [7:0] id,
                         input bit ok);
        bit   stopgo, hit, e_clr_id, e_err, e_go, e_buzz;
        bus.cmd_rdy = rdy;
        bus.cmd     = c;
        bus.ID_vld  = vld;
        bus.ID      = id;
        OK2Move     = ok;
        #4;
        stopgo   = rdy && (c[7:6] == 2'b00 || c[7:6] == 2'b01);
        hit      = vld && !stopgo && route.size() > 0 && id[5:0] == route[0];
        e_clr_id = vld && !stopgo;
        e_err    = rdy && c[7:6] == 2'b10 && route.size() == DEPTH && !hit;
        e_go     = route.size() > 0 && ok;
        a_clr_id = bus.clr_ID_vld;
        a_arr    = arrived;
        a_err    = cmd_err;
        check("clr_cmd_rdy", bus.clr_cmd_rdy, rdy);
        check("clr_ID_vld", bus.clr_ID_vld, e_clr_id);
        check("arrived", arrived, hit);
        check("cmd_err", cmd_err, e_err);
        check("go", go, e_go);
        if (route.size() > 0 && !ok) buzz_run++;
        else buzz_run = 0;
        if (rdy && c[7:6] == 2'b00) begin
            route.delete();
        end else if (rdy && c[7:6] == 2'b01) begin
            route.delete();
            route.push_back(c[5:0]);
        end else begin
            if (hit) void'(route.pop_front());
            if (rdy && c[7:6] == 2'b10 && !e_err) route.push_back(c[5:0]);
        end
        @(posedge clk);
        #1;
`ifdef CMD_INTF_BUZZER_EN
        e_buzz = ((buzz_run / BUZZ_HALF) % 2) == 1;
`else
        e_buzz = 1'b0;
`endif
        a_tr  = in_transit;
        a_cnt = route_cnt;
        check("in_transit", in_transit, route.size() > 0);
        check("route_cnt", route_cnt, route.size());
        check("buzz", buzz, e_buzz);
        check("buzz_n", buzz_n, !e_buzz);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_transit"}, in_transit, 0);
        check({tag, " route_cnt"}, route_cnt, 0);
        check({tag, " buzz"}, buzz, 0);
        check({tag, " buzz_n"}, buzz_n, 1);
        check({tag, " go"}, go, 0);
        check({tag, " arrived"}, arrived, 0);
        check({tag, " cmd_err"}, cmd_err, 0);
        check({tag, " clr_cmd_rdy"}, bus.clr_cmd_rdy, 0);
        check({tag, " clr_ID_vld"}, bus.clr_ID_vld, 0);
    endtask

    typedef struct {
        bit         rdy;
        logic [7:0] cmd;
        bit         vld;
        logic [7:0] id;
        bit         e_clr_id;
        bit         e_arr;
        bit         e_err;
        bit         e_tr;
        int         e_cnt;
    } vec_t;

    vec_t tbl [$];

    initial begin
        // rdy cmd vld id | clr_id arr err transit cnt
        tbl.push_back('{1, 8'h52, 0, 8'h00, 0, 0, 0, 1, 1}); // GO 0x12
        tbl.push_back('{0, 8'h00, 1, 8'h05, 1, 0, 0, 1, 1}); // wrong station
        tbl.push_back('{0, 8'h00, 1, 8'h12, 1, 1, 0, 0, 0}); // arrive
        tbl.push_back('{1, 8'h81, 0, 8'h00, 0, 0, 0, 1, 1}); // QUEUE 1..4
        tbl.push_back('{1, 8'h82, 0, 8'h00, 0, 0, 0, 1, 2});
        tbl.push_back('{1, 8'h83, 0, 8'h00, 0, 0, 0, 1, 3});
        tbl.push_back('{1, 8'h84, 0, 8'h00, 0, 0, 0, 1, 4});
        tbl.push_back('{1, 8'h85, 0, 8'h00, 0, 0, 1, 1, 4}); // full: dropped
        tbl.push_back('{0, 8'h00, 1, 8'h01, 1, 1, 0, 1, 3});
        tbl.push_back('{0, 8'h00, 1, 8'h02, 1, 1, 0, 1, 2});
        tbl.push_back('{0, 8'h00, 1, 8'h03, 1, 1, 0, 1, 1});
        tbl.push_back('{0, 8'h00, 1, 8'h04, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 8'h04, 1, 0, 0, 0, 0}); // idle: just consumed
        tbl.push_back('{1, 8'h81, 0, 8'h00, 0, 0, 0, 1, 1});
        tbl.push_back('{1, 8'h82, 0, 8'h00, 0, 0, 0, 1, 2});
        tbl.push_back('{1, 8'h83, 0, 8'h00, 0, 0, 0, 1, 3});
        tbl.push_back('{1, 8'h84, 0, 8'h00, 0, 0, 0, 1, 4});
        tbl.push_back('{1, 8'h85, 1, 8'h01, 1, 1, 0, 1, 4}); // full + pop: accepted
        tbl.push_back('{0, 8'h00, 1, 8'h02, 1, 1, 0, 1, 3});
        tbl.push_back('{0, 8'h00, 1, 8'h03, 1, 1, 0, 1, 2});
        tbl.push_back('{0, 8'h00, 1, 8'h04, 1, 1, 0, 1, 1});
        tbl.push_back('{0, 8'h00, 1, 8'h05, 1, 1, 0, 0, 0}); // tail was 0x05
        tbl.push_back('{1, 8'h87, 0, 8'h00, 0, 0, 0, 1, 1});
        tbl.push_back('{1, 8'h88, 0, 8'h00, 0, 0, 0, 1, 2});
        tbl.push_back('{1, 8'h89, 0, 8'h00, 0, 0, 0, 1, 3});
        tbl.push_back('{1, 8'h00, 1, 8'h07, 0, 0, 0, 0, 0}); // STOP beats the ID
        tbl.push_back('{0, 8'h00, 1, 8'h07, 1, 0, 0, 0, 0}); // ID consumed in idle

        rst_n       = 1'b0;
        bus.cmd     = 8'h00;
        bus.cmd_rdy = 1'b0;
        bus.ID      = 8'h00;
        bus.ID_vld  = 1'b0;
        OK2Move     = 1'b1;
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("post_reset");

        foreach (tbl[i]) begin
            apply(tbl[i].rdy, tbl[i].cmd, tbl[i].vld, tbl[i].id, 1'b1);
            check($sformatf("row%0d clr_ID_vld", i), a_clr_id, tbl[i].e_clr_id);
            check($sformatf("row%0d arrived", i), a_arr, tbl[i].e_arr);
            check($sformatf("row%0d cmd_err", i), a_err, tbl[i].e_err);
            check($sformatf("row%0d in_transit", i), a_tr, tbl[i].e_tr);
            check($sformatf("row%0d route_cnt", i), a_cnt, tbl[i].e_cnt);
        end

        // Obstructed transit: buzzer pattern over 10 enabled cycles, then clear the obstacle.
        begin
            bit pat [10];
`ifdef CMD_INTF_BUZZER_EN
            pat = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
`else
            pat = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
            apply(1'b1, 8'h50, 1'b0, 8'h00, 1'b0);
            for (int k = 0; k < 10; k++) begin
                apply(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
                check($sformatf("buzz_seq%0d", k + 1), buzz, pat[k]);
                check($sformatf("buzz_n_seq%0d", k + 1), buzz_n, !pat[k]);
            end
            apply(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            check("obstacle_clear buzz", buzz, 0);
            check("obstacle_clear buzz_n", buzz_n, 1);
            #4;
            check("obstacle_clear go", go, 1);
            #6;
        end

        // Asynchronous reset in the middle of a two-entry route.
        apply(1'b1, 8'h61, 1'b0, 8'h00, 1'b0);
        apply(1'b1, 8'ha2, 1'b0, 8'h00, 1'b0);
        check("pre_rst route_cnt", route_cnt, 2);
        bus.cmd_rdy = 1'b0;
        rst_n       = 1'b0;
        #2;
        check_reset_outputs("async_rst");
        route.delete();
        buzz_run = 0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply(1'b0, 8'h00, 1'b1, 8'h21, 1'b1);
        check("after_rst arrived", a_arr, 0);
        check("after_rst in_transit", a_tr, 0);

        // Randomized traffic against the route model.
        for (int n = 0; n < 600; n++) begin
            bit         rdy, vld, ok;
            logic [7:0] c, id;
            rdy = ($urandom_range(0, 9) < 4);
            c   = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
            if (c[7:6] != 2'b10 && $urandom_range(0, 2) != 0) c[7:6] = 2'b10;
            vld = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1 && route.size() > 0) id = {2'($urandom), route[0]};
            else id = {2'($urandom), 6'($urandom_range(0, 3))};
            ok = ($urandom_range(0, 3) != 0);
            apply(rdy, c, vld, id, ok);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
